switch_sender_multi: RTL and testbench



---
 rtl/switch_sender_multi_pkg.sv | 11 +
 rtl/switch_sender_multi_frame_serializer.sv | 69 ++++++
 rtl/switch_sender_multi.sv | 71 +++++++
 tb/tb_switch_sender_multi.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/switch_sender_multi_pkg.sv
// switch_sender_multi_pkg: frame states, line levels and a width helper shared by the switch sender.
package switch_sender_multi_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} frame_state_e;
  localparam logic START_LVL = 1'b1;
  localparam logic STOP_LVL = 1'b0;
  localparam logic LINE_IDLE = 1'b0;
  function automatic int clog2(input int v);
    for (int r = 0; r < 31; r++) if ((1 << r) >= v) return r;
    return 31;
  endfunction
endpackage

// File: rtl/switch_sender_multi_frame_serializer.sv
// switch_sender_multi_frame_serializer: sends start bit, WORD_W data bits MSB first, stop bit, each BIT_TICKS cycles.
// Ports: sysclk/rstn clock and async active-low reset; start loads word when idle;
// out serial line (idle low); busy high while a frame is on the line; done is high in the final cycle of the stop bit.
module switch_sender_multi_frame_serializer
  import switch_sender_multi_pkg::*;
#(
  parameter int WORD_W = 2,
  parameter int BIT_TICKS = 50000000
) (
  input  logic              sysclk,
  input  logic              rstn,
  input  logic              start,
  input  logic [WORD_W-1:0] word,
  output logic              out,
  output logic              busy,
  output logic              done
);
  localparam int TW = clog2(BIT_TICKS + 1);
  localparam int BW = clog2(WORD_W + 1);
  frame_state_e state;
  logic [TW-1:0] tick;
  logic [BW-1:0] bit_idx;
  logic [WORD_W-1:0] sh;
  logic bit_end;
  assign bit_end = tick == TW'(BIT_TICKS - 1);
  // done coincides with busy falling so the frame counter updates in the same edge
  assign done = state == STOP && bit_end;
  always_ff @(posedge sysclk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      tick <= '0;
      bit_idx <= '0;
      sh <= '0;
      out <= LINE_IDLE;
      busy <= 1'b0;
    end else begin
      tick <= (state == IDLE || bit_end) ? '0 : tick + 1'b1;
      case (state)
        IDLE: if (start) begin
          state <= START;
          out <= START_LVL;
          busy <= 1'b1;
          sh <= word;
        end
        START: if (bit_end) begin
          state <= DATA;
          out <= sh[WORD_W-1];
          sh <= sh << 1;
          bit_idx <= '0;
        end
        DATA: if (bit_end) begin
          if (bit_idx == BW'(WORD_W - 1)) begin
            state <= STOP;
            out <= STOP_LVL;
          end else begin
            out <= sh[WORD_W-1];
            sh <= sh << 1;
            bit_idx <= bit_idx + 1'b1;
          end
        end
        STOP: if (bit_end) begin
          state <= IDLE;
          out <= LINE_IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: rtl/switch_sender_multi.sv
// switch_sender_multi: priority-encodes switches and sends the code as a framed serial word on request.
// Ports: sysclk/rstn clock and async active-low reset; sw selection switches (highest index wins);
// write manual-send button; auto toggles auto-repeat on its rising edge; out serial line; busy frame in progress;
// auto_on auto-mode state; no_sel pulse when a request finds sw==0; frame_cnt completed frames (wraps).
module switch_sender_multi
  import switch_sender_multi_pkg::*;
#(
  parameter int NUM_SW = 4,
  parameter int WORD_W = 2,
  parameter int BIT_TICKS = 50000000,
  parameter int AUTO_TICKS = 50000000,
  parameter int CNT_W = 8
) (
  input  logic              sysclk,
  input  logic              rstn,
  input  logic [NUM_SW-1:0] sw,
  input  logic              write,
  input  logic              auto,
  output logic              out,
  output logic              busy,
  output logic              auto_on,
  output logic              no_sel,
  output logic [CNT_W-1:0]  frame_cnt
);
  localparam int AW = clog2(AUTO_TICKS);
  logic write_q, auto_q, pending, done;
  logic write_rise, auto_rise, auto_req, req, serve, start;
  logic [AW-1:0] timer;
  logic [WORD_W-1:0] code;
  assign write_rise = write & ~write_q;
  assign auto_rise = auto & ~auto_q;
  assign auto_req = auto_on && timer == AW'(AUTO_TICKS - 1);
  assign req = write_rise | auto_req;
  assign serve = ~busy & (req | pending);
  assign start = serve & (|sw);
  always_comb begin
    code = '0;
    for (int i = 0; i < NUM_SW; i++) if (sw[i]) code = WORD_W'(i);
  end
  always_ff @(posedge sysclk or negedge rstn)
    if (!rstn) begin
      // previous levels reset high so a button held through reset is not seen as a press
      write_q <= 1'b1;
      auto_q <= 1'b1;
      auto_on <= 1'b0;
      timer <= '0;
      pending <= 1'b0;
      no_sel <= 1'b0;
      frame_cnt <= '0;
    end else begin
      write_q <= write;
      auto_q <= auto;
      auto_on <= auto_on ^ auto_rise;
      timer <= (auto_on && !auto_rise && !auto_req) ? timer + 1'b1 : '0;
      pending <= serve ? 1'b0 : pending | req;
      no_sel <= serve & ~(|sw);
      frame_cnt <= frame_cnt + CNT_W'(done);
    end
  switch_sender_multi_frame_serializer #(
    .WORD_W(WORD_W),
    .BIT_TICKS(BIT_TICKS)
  ) u_ser (
    .sysclk(sysclk),
    .rstn(rstn),
    .start(start),
    .word(code),
    .out(out),
    .busy(busy),
    .done(done)
  );
endmodule

// File: tb/tb_switch_sender_multi.sv
// tb_switch_sender_multi: directed checks of framing, requests, auto mode, counter wrap and reset abort.
module tb_switch_sender_multi;
  logic sysclk = 1'b0;
  logic rstn;
  logic [3:0] sw;
  logic write, auto;
  logic out, busy, auto_on, no_sel;
  logic [2:0] frame_cnt;
  int vecs = 0;
  int miss = 0;

  switch_sender_multi #(
    .NUM_SW(4),
    .WORD_W(2),
    .BIT_TICKS(4),
    .AUTO_TICKS(64),
    .CNT_W(3)
  ) dut (
    .sysclk(sysclk),
    .rstn(rstn),
    .sw(sw),
    .write(write),
    .auto(auto),
    .out(out),
    .busy(busy),
    .auto_on(auto_on),
    .no_sel(no_sel),
    .frame_cnt(frame_cnt)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // entered at the sample just after the edge that started the frame; leaves one cycle after busy falls
  task automatic frame_check(input logic [1:0] code);
    logic [3:0] bits;
    bits = {1'b1, code, 1'b0};
    for (int i = 0; i < 16; i++) begin
      chk("frame_out", out, bits[3 - i / 4]);
      chk("frame_busy", busy, 1);
      @(negedge sysclk);
    end
    chk("frame_end_busy", busy, 0);
    chk("frame_end_out", out, 0);
  endtask

  task automatic pulse_write();
    write = 1'b1;
    @(negedge sysclk);
    write = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    write = 1'b1;
    auto = 1'b0;
    sw = 4'b0100;
    repeat (2) @(negedge sysclk);
    chk("rst_out", out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_auto_on", auto_on, 0);
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge sysclk);
      chk("held_busy", busy, 0);
      chk("held_out", out, 0);
    end
    chk("held_cnt", frame_cnt, 0);
    chk("held_no_sel", no_sel, 0);
    write = 1'b0;
    @(negedge sysclk);

    pulse_write();
    frame_check(2'b10);
    chk("cnt_after_1", frame_cnt, 1);

    sw = 4'b1010;
    pulse_write();
    frame_check(2'b11);
    chk("cnt_after_2", frame_cnt, 2);

    sw = 4'b0000;
    pulse_write();
    chk("no_sel_pulse", no_sel, 1);
    chk("no_sel_busy", busy, 0);
    chk("no_sel_out", out, 0);
    @(negedge sysclk);
    chk("no_sel_drop", no_sel, 0);
    chk("no_sel_busy2", busy, 0);
    chk("no_sel_cnt", frame_cnt, 2);

    sw = 4'b0100;
    pulse_write();
    repeat (2) @(negedge sysclk);
    pulse_write();
    repeat (4) @(negedge sysclk);
    pulse_write();
    repeat (8) @(negedge sysclk);
    chk("b2b_gap_busy", busy, 0);
    chk("b2b_cnt_3", frame_cnt, 3);
    @(negedge sysclk);
    frame_check(2'b10);
    chk("b2b_cnt_4", frame_cnt, 4);
    @(negedge sysclk);
    chk("b2b_only_one", busy, 0);

    sw = 4'b0001;
    auto = 1'b1;
    @(negedge sysclk);
    auto = 1'b0;
    chk("auto_on_set", auto_on, 1);
    chk("auto_idle", busy, 0);
    repeat (63) @(negedge sysclk);
    chk("auto_before_1", busy, 0);
    @(negedge sysclk);
    frame_check(2'b00);
    chk("auto_cnt_5", frame_cnt, 5);
    repeat (47) @(negedge sysclk);
    chk("auto_before_2", busy, 0);
    @(negedge sysclk);
    frame_check(2'b00);
    chk("auto_cnt_6", frame_cnt, 6);
    auto = 1'b1;
    @(negedge sysclk);
    auto = 1'b0;
    chk("auto_on_clr", auto_on, 0);
    for (int i = 0; i < 80; i++) begin
      @(negedge sysclk);
      chk("auto_off_quiet", busy, 0);
    end
    chk("auto_off_cnt", frame_cnt, 6);

    sw = 4'b1000;
    pulse_write();
    frame_check(2'b11);
    chk("cnt_7", frame_cnt, 7);
    pulse_write();
    frame_check(2'b11);
    chk("cnt_wrap", frame_cnt, 0);
    sw = 4'b0100;
    pulse_write();
    frame_check(2'b10);
    chk("cnt_1_again", frame_cnt, 1);

    pulse_write();
    repeat (6) @(negedge sysclk);
    chk("mid_data_out", out, 1);
    chk("mid_data_busy", busy, 1);
    rstn = 1'b0;
    #1;
    chk("abort_out", out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cnt", frame_cnt, 0);
    @(negedge sysclk);
    rstn = 1'b1;
    repeat (20) @(negedge sysclk);
    chk("post_abort_busy", busy, 0);
    chk("post_abort_out", out, 0);
    chk("post_abort_cnt", frame_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
